// File: rtl/aes_pkg.sv
// Shared AES types, the AES-128 round count, xtime and the forward S-box.
// Used by the key schedule and by the byte-substitution stage.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    localparam int AES128_ROUNDS = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_STEP  = 2'd2
    } ks_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_expand_if.sv
// Strobe/data bundle between the round pipeline (master) and key_expand (slave).
// With KEY_CACHE_EN defined the bundle also carries the key_rewind strobe.
interface key_expand_if;
    import aes_pkg::*;

    logic       key_load;
    block_t     key_in;
    logic       key_req;
`ifdef KEY_CACHE_EN
    logic       key_rewind;
`endif
    block_t     round_key;
    logic [3:0] round_idx;
    logic       key_valid;
    logic       last_key;
    logic       busy;

`ifdef KEY_CACHE_EN
    modport master (output key_load, key_in, key_req, key_rewind,
                    input  round_key, round_idx, key_valid, last_key, busy);
    modport slave  (input  key_load, key_in, key_req, key_rewind,
                    output round_key, round_idx, key_valid, last_key, busy);
`else
    modport master (output key_load, key_in, key_req,
                    input  round_key, round_idx, key_valid, last_key, busy);
    modport slave  (input  key_load, key_in, key_req,
                    output round_key, round_idx, key_valid, last_key, busy);
`endif
endinterface

// File: rtl/key_expand_sub_word.sv
// sub_word: four parallel S-box lookups on one 32-bit word, purely combinational.
module sub_word
    import aes_pkg::*;
(
    input  word_t w_i,
    output word_t w_o
);
    assign w_o = {SBOX[w_i[31:24]], SBOX[w_i[23:16]], SBOX[w_i[15:8]], SBOX[w_i[7:0]]};
endmodule

// File: rtl/key_expand.sv
// AES-128 on-the-fly key schedule: presents round keys 0..10, advancing one per key_req.
// PIPE_SUBWORD=1 registers SubWord (two-cycle step); KEY_CACHE_EN adds a replay cache and key_rewind.
module key_expand
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS   = AES128_ROUNDS,
    parameter int PIPE_SUBWORD = 0
) (
    input logic         clk,
    input logic         rst,
    key_expand_if.slave kif
);
    localparam logic [3:0] LAST_IDX = 4'(AES128_ROUNDS);

    if (NUM_ROUNDS != AES128_ROUNDS) begin : g_bad_rounds
        $error("key_expand: only NUM_ROUNDS=10 (AES-128) is supported");
    end
    if ((PIPE_SUBWORD != 0) && (PIPE_SUBWORD != 1)) begin : g_bad_pipe
        $error("key_expand: PIPE_SUBWORD must be 0 or 1");
    end

    ks_state_e  state_q;
    block_t     key_q;
    logic [3:0] idx_q;
    logic       valid_q;
    logic       busy_q;
    logic [7:0] rcon_q;

    word_t      rot_s;
    word_t      sub_s;
    word_t      sub_sel_s;
    block_t     next_key_d;

    function automatic block_t expand(input block_t k, input word_t sw, input logic [7:0] rc);
        word_t w0;
        word_t w1;
        word_t w2;
        word_t w3;
        w0 = k[127:96] ^ sw ^ {rc, 24'h000000};
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign rot_s = {key_q[23:0], key_q[31:24]};

    sub_word u_sub_word (
        .w_i (rot_s),
        .w_o (sub_s)
    );

    if (PIPE_SUBWORD != 0) begin : g_pipe
        word_t sub_q;

        // key_q is frozen during STEP, so the value captured on the request cycle is the right one.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sub_q <= 32'h0000_0000;
            end else begin
                sub_q <= sub_s;
            end
        end

        assign sub_sel_s = sub_q;
    end else begin : g_comb
        assign sub_sel_s = sub_s;
    end

    assign next_key_d = expand(key_q, sub_sel_s, rcon_q);

`ifdef KEY_CACHE_EN
    block_t cache_q [11];
    logic   full_q;
    logic   replay_q;

    // Cache every presented key at its index; full once idx 10 has been shown since the last load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
            for (int i = 0; i < 11; i++) begin
                cache_q[i] <= 128'h0;
            end
        end else begin
            if (valid_q && (idx_q <= LAST_IDX)) begin
                cache_q[idx_q] <= key_q;
            end
            if (kif.key_load) begin
                full_q <= 1'b0;
            end else if (valid_q && (idx_q == LAST_IDX)) begin
                full_q <= 1'b1;
            end
        end
    end
`endif

    // Schedule FSM: load restarts, rewind replays the cache, request advances one round.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            key_q   <= 128'h0;
            idx_q   <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            rcon_q  <= 8'h01;
`ifdef KEY_CACHE_EN
            replay_q <= 1'b0;
`endif
        end else if (kif.key_load) begin
            state_q <= ST_VALID;
            key_q   <= kif.key_in;
            idx_q   <= 4'd0;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            rcon_q  <= 8'h01;
`ifdef KEY_CACHE_EN
            replay_q <= 1'b0;
`endif
        end
`ifdef KEY_CACHE_EN
        else if (kif.key_rewind && full_q) begin
            state_q  <= ST_VALID;
            key_q    <= cache_q[0];
            idx_q    <= 4'd0;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            replay_q <= 1'b1;
        end
`endif
        else begin
            case (state_q)
                ST_VALID: begin
                    if (kif.key_req) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_IDLE;
                            valid_q <= 1'b0;
                        end
`ifdef KEY_CACHE_EN
                        else if (replay_q) begin
                            key_q <= cache_q[idx_q + 4'd1];
                            idx_q <= idx_q + 4'd1;
                        end
`endif
                        else if (PIPE_SUBWORD != 0) begin
                            state_q <= ST_STEP;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            key_q  <= next_key_d;
                            idx_q  <= idx_q + 4'd1;
                            rcon_q <= xtime(rcon_q);
                        end
                    end
                end
                ST_STEP: begin
                    state_q <= ST_VALID;
                    key_q   <= next_key_d;
                    idx_q   <= idx_q + 4'd1;
                    rcon_q  <= xtime(rcon_q);
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign kif.round_key = key_q;
    assign kif.round_idx = idx_q;
    assign kif.key_valid = valid_q;
    assign kif.last_key  = valid_q && (idx_q == LAST_IDX);
    assign kif.busy      = (PIPE_SUBWORD != 0) ? busy_q : 1'b0;

endmodule

// File: tb/tb_key_expand.sv
// Bench for key_expand: one DUT per PIPE_SUBWORD setting fed the same strobes, a scoreboard per DUT,
// and a reference key schedule derived from GF(2^8) arithmetic (S-box rebuilt from inverse + affine map).
module tb_key_expand;
    import aes_pkg::*;

    typedef logic [134:0] obs_t;   // {key_valid, busy, last_key, round_idx, round_key}

`ifdef KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   rst;
    logic   key_load;
    logic   key_req;
    block_t key_in;
`ifdef KEY_CACHE_EN
    logic   key_rewind;
`endif

    always #5 clk = ~clk;

    key_expand_if kif0 ();
    key_expand_if kif1 ();

    assign kif0.key_load = key_load;
    assign kif0.key_in   = key_in;
    assign kif0.key_req  = key_req;
    assign kif1.key_load = key_load;
    assign kif1.key_in   = key_in;
    assign kif1.key_req  = key_req;
`ifdef KEY_CACHE_EN
    assign kif0.key_rewind = key_rewind;
    assign kif1.key_rewind = key_rewind;
`endif

    key_expand #(.NUM_ROUNDS(10), .PIPE_SUBWORD(0)) dut0 (.clk(clk), .rst(rst), .kif(kif0.slave));
    key_expand #(.NUM_ROUNDS(10), .PIPE_SUBWORD(1)) dut1 (.clk(clk), .rst(rst), .kif(kif1.slave));

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbox_m [256];
    block_t     m_sched [11];
    int         m_state [2];   // 0 idle, 1 key shown, 2 step in progress
    int         m_idx   [2];
    block_t     m_shown [2];
    bit         m_full  [2];
    bit         m_replay[2];
    obs_t       q0[$];
    obs_t       q1[$];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x_in, input int n);
        logic [7:0] x;
        x = x_in;
        for (int i = 0; i < n; i++) x = {x[6:0], x[7]};
        return x;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS-197 word recurrence over all 44 words.
    task automatic load_sched(input block_t k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_state[p] = 0; m_idx[p] = 0; m_shown[p] = 128'h0; m_full[p] = 1'b0; m_replay[p] = 1'b0;
        end
    endtask

    task automatic model_cycle(input int p, input bit ld, input bit rq, input bit rw);
        bit nf;
        nf = ld ? 1'b0 : (m_full[p] | (m_state[p] == 1 && m_idx[p] == 10));
        if (ld) begin
            m_state[p] = 1; m_idx[p] = 0; m_shown[p] = m_sched[0]; m_replay[p] = 1'b0;
        end else if (CACHE && rw && m_full[p]) begin
            m_state[p] = 1; m_idx[p] = 0; m_shown[p] = m_sched[0]; m_replay[p] = 1'b1;
        end else if (m_state[p] == 1 && rq) begin
            if (m_idx[p] == 10) m_state[p] = 0;
            else if (p == 1 && !m_replay[p]) m_state[p] = 2;
            else begin
                m_idx[p] = m_idx[p] + 1; m_shown[p] = m_sched[m_idx[p]];
            end
        end else if (m_state[p] == 2) begin
            m_state[p] = 1; m_idx[p] = m_idx[p] + 1; m_shown[p] = m_sched[m_idx[p]];
        end
        m_full[p] = nf;
    endtask

    function automatic obs_t model_obs(input int p);
        return {m_state[p] == 1, m_state[p] == 2, (m_state[p] == 1) && (m_idx[p] == 10),
                4'(m_idx[p]), m_shown[p]};
    endfunction

    function automatic obs_t dut_obs(input int p);
        if (p == 0) return {kif0.key_valid, kif0.busy, kif0.last_key, kif0.round_idx, kif0.round_key};
        else        return {kif1.key_valid, kif1.busy, kif1.last_key, kif1.round_idx, kif1.round_key};
    endfunction

    function automatic void check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual valid=%0b busy=%0b last=%0b idx=%0d key=%h, expected valid=%0b busy=%0b last=%0b idx=%0d key=%h",
                     name, act[134], act[133], act[132], act[131:128], act[127:0],
                     exp[134], exp[133], exp[132], exp[131:128], exp[127:0]);
        end
    endfunction

    task automatic kat(input string name, input int p, input int idx, input bit last, input block_t k);
        check(name, dut_obs(p), {1'b1, 1'b0, last, 4'(idx), k});
    endtask

    task automatic step(input bit ld, input block_t k, input bit rq, input bit rw);
        key_load = ld;
        key_in   = k;
        key_req  = rq;
`ifdef KEY_CACHE_EN
        key_rewind = rw;
`endif
        if (ld) load_sched(k);
        @(posedge clk);
        #1;
        model_cycle(0, ld, rq, rw);
        model_cycle(1, ld, rq, rw);
        q0.push_back(model_obs(0));
        q1.push_back(model_obs(1));
    endtask

    // Scoreboard monitor: one expected observation per DUT per cycle, compared mid-cycle.
    always @(negedge clk) begin : monitor
        obs_t e;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            check("sb_pipe0", dut_obs(0), e);
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            check("sb_pipe1", dut_obs(1), e);
        end
    end

    initial begin
        block_t fips_key;
        block_t fips_r1;
        block_t fips_r10;
        block_t seq_key;
        block_t seq_r1;
        block_t rk;
        bit     ld;
        bit     rq;
        bit     rw;

        fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_r1  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_r10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        seq_key  = 128'h000102030405060708090a0b0c0d0e0f;
        seq_r1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

        rst = 1'b0; key_load = 1'b0; key_req = 1'b0; key_in = 128'h0;
`ifdef KEY_CACHE_EN
        key_rewind = 1'b0;
`endif
        build_sbox();
        for (int r = 0; r < 11; r++) m_sched[r] = 128'h0;
        model_reset();

        #3;
        check("reset_pipe0", dut_obs(0), 135'h0);
        check("reset_pipe1", dut_obs(1), 135'h0);
        #19 rst = 1'b1;

        // FIPS-197 vector with key_req held through completion on both DUTs.
        step(1'b1, fips_key, 1'b0, 1'b0);
        kat("fips_idx0_pipe0", 0, 0, 1'b0, fips_key);
        kat("fips_idx0_pipe1", 1, 0, 1'b0, fips_key);
        for (int c = 1; c <= 23; c++) begin
            step(1'b0, 128'h0, 1'b1, 1'b0);
            if (c == 1)  kat("fips_idx1_pipe0", 0, 1, 1'b0, fips_r1);
            if (c == 10) kat("fips_idx10_pipe0", 0, 10, 1'b1, fips_r10);
            if (c == 20) kat("fips_idx10_pipe1", 1, 10, 1'b1, fips_r10);
        end

        // Restart: load wins over a simultaneous request at idx 4.
        step(1'b1, fips_key, 1'b0, 1'b0);
        repeat (4) step(1'b0, 128'h0, 1'b1, 1'b0);
        step(1'b1, seq_key, 1'b1, 1'b0);
        kat("restart_idx0_pipe0", 0, 0, 1'b0, seq_key);
        step(1'b0, 128'h0, 1'b1, 1'b0);
        kat("restart_idx1_pipe0", 0, 1, 1'b0, seq_r1);

        // Asynchronous reset in mid-expansion, released off the clock edge.
        step(1'b1, fips_key, 1'b0, 1'b0);
        repeat (6) step(1'b0, 128'h0, 1'b1, 1'b0);
        key_req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_pipe0", dut_obs(0), 135'h0);
        check("async_rst_pipe1", dut_obs(1), 135'h0);
        model_reset();
        #1 rst = 1'b1;
        repeat (3) step(1'b0, 128'h0, 1'b1, 1'b0);

`ifdef KEY_CACHE_EN
        // Replay from cache runs at one key per cycle on both DUTs.
        step(1'b1, fips_key, 1'b0, 1'b0);
        repeat (25) step(1'b0, 128'h0, 1'b1, 1'b0);
        step(1'b0, 128'h0, 1'b0, 1'b1);
        kat("rewind_idx0_pipe1", 1, 0, 1'b0, fips_key);
        repeat (10) step(1'b0, 128'h0, 1'b1, 1'b0);
        kat("rewind_idx10_pipe1", 1, 10, 1'b1, fips_r10);
`endif

        // Randomized strobes, including loads landing inside a step.
        for (int c = 0; c < 400; c++) begin
            ld = ($urandom_range(0, 23) == 0);
            rq = ($urandom_range(0, 3) != 0);
            rw = ($urandom_range(0, 7) == 0);
            rk = {$urandom, $urandom, $urandom, $urandom};
            if (ld && ($urandom_range(0, 3) == 0)) rk = fips_key;
            step(ld, rk, rq, rw);
        end

        key_load = 1'b0; key_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ((q0.size() != 0) || (q1.size() != 0)) begin
            n_fail++;
            $display("FAIL sb_drain: actual %0d/%0d pending, expected 0/0", q0.size(), q1.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_expand.md
Name: key_expand

Overview:
- On-the-fly AES-128 key schedule that generates round keys 0..10 in order.
- Sits directly upstream of the round stage and drives its key input.
- Consumer pacing: one new round key per request strobe, so the key advances in lockstep with the round pipeline's enable chain.

Parameters:
- NUM_ROUNDS, 10, number of rounds after the initial AddRoundKey. Only 10 (AES-128) is supported; any other value is an elaboration error.
- PIPE_SUBWORD, 0, 0 = next key computed in one cycle; 1 = SubWord output registered, two-cycle step.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- key_load  input  1  strobe: capture key_in and restart the schedule.
- key_in  input  128  cipher key, byte 0 in bits [127:120].
- key_req  input  1  strobe: advance to the next round key.
- round_key  output  128  current round key.
- round_idx  output  4  index of round_key, 0..10.
- key_valid  output  1  round_key/round_idx are valid.
- last_key  output  1  key_valid && round_idx==10.
- busy  output  1  step in progress (PIPE_SUBWORD=1 only; tied 0 otherwise).

Behaviour:
- Reset (rst low, async): round_key=0, round_idx=0, key_valid=0, last_key=0, busy=0, rcon=0x01, FSM=IDLE.
- FSM states: IDLE, VALID, STEP (STEP exists only when PIPE_SUBWORD=1).
- IDLE: key_load -> VALID next cycle with round_key=key_in, round_idx=0, key_valid=1. key_req ignored.
- VALID, key_req, round_idx<10:
  - PIPE_SUBWORD=0: next cycle round_key=expand(round_key, rcon), round_idx+1, rcon=xtime(rcon); key_valid stays 1.
  - PIPE_SUBWORD=1: next cycle STEP (key_valid=0, busy=1); the following cycle returns to VALID with the new key.
- VALID, key_req, round_idx==10: next cycle IDLE, key_valid=0, round_key holds its last value.
- expand():
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
  - w0 = bits [127:96].
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36. xtime = (x<<1) ^ (x[7] ? 8'h1b : 0); reload to 0x01 on key_load.
- key_load has priority over key_req in any state, including STEP: it aborts the step and the next cycle shows key_in at idx 0.
- key_req in IDLE or STEP: ignored (not queued).
- key_req held high: advances once per cycle (PIPE_SUBWORD=0) or once per two cycles (PIPE_SUBWORD=1).
- key_load and key_req are not edge-detected: each cycle high counts.
- No combinational path from inputs to outputs; all outputs are registered except last_key, which is decoded from registers.

Optional Feature:
- KEY_CACHE_EN defined:
  - Adds an 11x128 register cache and input port key_rewind (1 bit).
  - Each generated key (idx 0..10) is written at index round_idx.
  - Once idx 10 has been produced, a cached_full flag sets.
  - key_rewind while cached_full: next cycle round_key=cache[0], idx 0, key_valid=1.
  - Subsequent key_req then read the cache with one-cycle latency regardless of PIPE_SUBWORD.
  - key_rewind without cached_full: ignored.
  - key_load clears cached_full. Priority: key_load > key_rewind > key_req.
- KEY_CACHE_EN undefined: no cache, no key_rewind port; re-running the schedule requires key_load.

Decomposition:
- aes_pkg contains:
  - typedefs word_t (32 bits) and block_t (128 bits).
  - constant AES128_ROUNDS=10.
  - function xtime.
  - 256-entry S-box constant, shared with the substitution stage.
- One sub-module: sub_word, four parallel S-box lookups on a word_t. It is combinational; the optional output register is controlled by PIPE_SUBWORD in the parent.

Test Plan:
- FIPS-197 key: key_load with 2b7e151628aed2a6abf7158809cf4f3c, then 10 key_req.
  - idx0 shows the key.
  - idx1 = a0fafe1788542cb123a339392a6c7605.
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with last_key=1.
- Completion: key_req at idx 10 -> key_valid=0 next cycle; further key_req leave outputs unchanged.
- Restart: key_load of 000102030405060708090a0b0c0d0e0f asserted together with key_req at idx 4 -> next cycle idx 0 with the new key. idx1 = d6aa74fdd2af72fadaa678f1d6ab76fe.
- Async reset: rst low mid-expansion (idx 6), released off the clock edge -> all outputs 0 immediately; key_req afterwards ignored until key_load.
- PIPE_SUBWORD=1: continuous key_req -> key_valid toggles 1,0,1,0; same FIPS-197 keys reached by cycle 21 after load; key_load during STEP aborts the step.
- KEY_CACHE_EN: after full expansion, key_rewind -> idx0 = 2b7e...4f3c; 10 key_req reproduce the identical sequence at one key per cycle.
